sos_cascade_sequencer: RTL and testbench
========================================

Name: sos_cascade_sequencer

Overview:
- Sequences one shared biquad (SOS) datapath through a cascade of NUM_STAGES second-order sections per input sample.
- Holds a run-time-writable coefficient bank per stage.
- On each sample_trig, runs stage 0..N-1 in order, feeding each stage's output into the next, then presents the final result.
- Sits between the sample-rate trigger/ADC path and the shared SOS datapath. The datapath keeps its per-stage delay state, indexed by dp_stage.

Parameters:
- COEF_SIZE, 20, coefficient width. Q2.18 at the default, so 1.0 = 262144.
- DATA_SIZE, 24, sample width, two's complement.
- NUM_STAGES, 4, number of cascaded sections. Must be at least 1.
- TIMEOUT, 255, maximum cycles to wait for dp_done before aborting.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- data_in  in  DATA_SIZE  input sample, captured on sample_trig
- sample_trig  in  1  one-cycle start-of-sample pulse
- data_out  out  DATA_SIZE  final cascade output, held until the next result
- data_valid  out  1  one-cycle pulse when data_out updates
- busy  out  1  high whenever state is not IDLE
- overrun  out  1  sticky flag: sample_trig arrived while busy
- timeout_err  out  1  sticky flag: datapath failed to finish within TIMEOUT
- err_clr  in  1  clears overrun and timeout_err
- cfg_we  in  1  coefficient write request
- cfg_ready  out  1  equals not busy; a write is accepted only when cfg_we and cfg_ready are both high
- cfg_addr  in  STAGE_W+3  {stage, coef_idx}; coef_idx 0..5 = B0, B1, B2, A1, A2, GAIN
- cfg_data  in  COEF_SIZE  coefficient value
- dp_start  out  1  one-cycle start pulse to the datapath
- dp_stage  out  STAGE_W  stage index, held stable from dp_start until dp_done
- dp_data_in  out  DATA_SIZE  stage input sample
- dp_b0, dp_b1, dp_b2, dp_a1, dp_a2, dp_gain  out  COEF_SIZE each  coefficients of dp_stage
- dp_done  in  1  datapath result-valid pulse
- dp_data_out  in  DATA_SIZE  stage result

Behaviour:
- Reset values (reset low, asynchronous):
  - State = IDLE, stage = 0.
  - data_out, dp_data_in = 0.
  - data_valid, dp_start, overrun, timeout_err = 0.
  - Every stage's coefficient bank = pass-through: B0 = GAIN = 1<<(COEF_SIZE-2); B1 = B2 = A1 = A2 = 0.
- STAGE_W = max(1, clog2(NUM_STAGES)).
- FSM states: IDLE, START, WAIT, OUT.
- IDLE, on sample_trig: work <= data_in, stage <= 0, go to START.
- START: dp_start = 1 for one cycle; dp_data_in = work; go to WAIT; watchdog counter <= 0.
- WAIT:
  - On dp_done: work <= dp_data_out.
    - If stage == NUM_STAGES-1, go to OUT.
    - Otherwise stage++ and go to START.
  - Without dp_done: counter++. When counter reaches TIMEOUT: set timeout_err, go to IDLE, leave data_out unchanged, emit no data_valid.
- OUT: data_out <= work, data_valid = 1 for one cycle, go to IDLE.
- Latency: trig→valid = 1 + NUM_STAGES × (2 + L_dp) cycles, where L_dp is the cycles from dp_start to dp_done. The bench checks this exact value with a fixed-latency datapath model.
- sample_trig when not in IDLE (including the OUT cycle): sample is dropped and overrun is set.
- sample_trig and err_clr in the same cycle: set wins.
- dp_done outside WAIT: ignored.
- dp_coefs: combinational read of bank[dp_stage]. Valid whenever dp_stage is driven.
- Config writes:
  - Accepted only in IDLE, which guarantees coefficients never change mid-sample.
  - coef_idx 6..7 or stage ≥ NUM_STAGES: write is silently dropped.
  - cfg_we and sample_trig in the same IDLE cycle: the write commits and the sample starts. The new coefficients apply to that sample.
- No arithmetic is performed in this block. Samples pass through unmodified in width.

Decomposition:
- Shared package holds:
  - coefficient index constants COEF_B0..COEF_GAIN (0..5)
  - COEF_ONE
  - FSM state encoding
  - the STAGE_W function
- One sub-module, sos_coef_bank: NUM_STAGES×6 register file with synchronous write port, combinational 6-wide read port, and pass-through reset.
- The FSM, watchdog and error flags stay in the top module.

Test Plan:
- Reset, then one trig with data_in = 24'h001000 and a pass-through datapath model (L_dp = 3) → exactly one data_valid pulse, data_out = 24'h001000 at cycle 1 + 4×5 = 21; dp_stage sequence 0, 1, 2, 3.
- Write B1 = 20'd720683 to stage 2 in IDLE, then trig → dp_b1 = 720683 only while dp_stage = 2; all other stages show B1 = 0. A write to coef_idx 7 leaves the bank unchanged.
- Datapath model returns its input + 1 per stage; data_in = 100 → data_out = 104.
- Second trig while busy → overrun = 1, only one data_valid produced; err_clr → overrun = 0. cfg_we while busy → cfg_ready = 0 and the bank is unchanged.
- Datapath never asserts dp_done → timeout_err = 1 exactly TIMEOUT cycles after entering WAIT, busy = 0, no data_valid; the next trig completes normally.
- Assert reset in WAIT of stage 1 → all outputs at their reset values immediately (asynchronous), bank back to pass-through, no data_valid after release.

Source files
------------

// File: rtl/sos_cascade_sequencer_pkg.sv
// sos_cascade_sequencer_pkg: coefficient indices, FSM encoding and sizing helpers shared by the cascade sequencer
package sos_cascade_sequencer_pkg;
  localparam int COEF_B0   = 0;
  localparam int COEF_B1   = 1;
  localparam int COEF_B2   = 2;
  localparam int COEF_A1   = 3;
  localparam int COEF_A2   = 4;
  localparam int COEF_GAIN = 5;
  localparam int NUM_COEFS = 6;
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;
  function automatic int stage_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [31:0] coef_one(int w);
    return 32'd1 << (w - 2);
  endfunction
endpackage

// File: rtl/sos_coef_bank.sv
// sos_coef_bank: per-stage biquad coefficient register file, reset to pass-through
// ports: clk/reset (async active-low); we/wr_stage/wr_idx/wr_data write port; rd_stage -> rd_coefs (combinational)
module sos_coef_bank import sos_cascade_sequencer_pkg::*; #(
  parameter int COEF_SIZE  = 20,
  parameter int NUM_STAGES = 4,
  parameter int STAGE_W    = stage_w(NUM_STAGES)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                we,
  input  logic [STAGE_W-1:0]                  wr_stage,
  input  logic [2:0]                          wr_idx,
  input  logic [COEF_SIZE-1:0]                wr_data,
  input  logic [STAGE_W-1:0]                  rd_stage,
  output logic [NUM_COEFS-1:0][COEF_SIZE-1:0] rd_coefs
);
  localparam logic [COEF_SIZE-1:0] ONE = COEF_SIZE'(coef_one(COEF_SIZE));
  localparam logic [NUM_COEFS-1:0][COEF_SIZE-1:0] PASS = {ONE, {(4*COEF_SIZE){1'b0}}, ONE};
  logic [NUM_COEFS-1:0][COEF_SIZE-1:0] bank [NUM_STAGES];
  logic hit;
  // out-of-range index or stage drops the write silently
  assign hit = we && int'(wr_idx) < NUM_COEFS && int'(wr_stage) < NUM_STAGES;
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int s = 0; s < NUM_STAGES; s++) bank[s] <= PASS;
    else if (hit)
      bank[wr_stage][wr_idx] <= wr_data;
  assign rd_coefs = bank[rd_stage];
endmodule

// File: rtl/sos_cascade_sequencer.sv
// sos_cascade_sequencer: runs one shared biquad datapath through NUM_STAGES sections per sample
// ports: sample path (data_in, sample_trig -> data_out, data_valid), status (busy, overrun, timeout_err, err_clr),
//        config (cfg_we, cfg_ready, cfg_addr={stage,idx}, cfg_data), datapath (dp_start, dp_stage, dp_data_in, dp_* coefs, dp_done, dp_data_out)
module sos_cascade_sequencer import sos_cascade_sequencer_pkg::*; #(
  parameter int COEF_SIZE  = 20,
  parameter int DATA_SIZE  = 24,
  parameter int NUM_STAGES = 4,
  parameter int TIMEOUT    = 255,
  localparam int STAGE_W   = stage_w(NUM_STAGES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 sample_trig,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout_err,
  input  logic                 err_clr,
  input  logic                 cfg_we,
  output logic                 cfg_ready,
  input  logic [STAGE_W+2:0]   cfg_addr,
  input  logic [COEF_SIZE-1:0] cfg_data,
  output logic                 dp_start,
  output logic [STAGE_W-1:0]   dp_stage,
  output logic [DATA_SIZE-1:0] dp_data_in,
  output logic [COEF_SIZE-1:0] dp_b0,
  output logic [COEF_SIZE-1:0] dp_b1,
  output logic [COEF_SIZE-1:0] dp_b2,
  output logic [COEF_SIZE-1:0] dp_a1,
  output logic [COEF_SIZE-1:0] dp_a2,
  output logic [COEF_SIZE-1:0] dp_gain,
  input  logic                 dp_done,
  input  logic [DATA_SIZE-1:0] dp_data_out
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  state_t state, state_next;
  logic [DATA_SIZE-1:0] work;
  logic [STAGE_W-1:0] stage;
  logic [CNT_W-1:0] cnt;
  logic last, cnt_hit;
  logic [NUM_COEFS-1:0][COEF_SIZE-1:0] coefs;
  assign last       = stage == STAGE_W'(NUM_STAGES - 1);
  assign cnt_hit    = cnt == CNT_W'(TIMEOUT - 1);
  assign cfg_ready  = state == S_IDLE;
  assign busy       = !cfg_ready;
  assign data_valid = state == S_OUT;
  assign dp_stage   = stage;
  assign dp_b0      = coefs[COEF_B0];
  assign dp_b1      = coefs[COEF_B1];
  assign dp_b2      = coefs[COEF_B2];
  assign dp_a1      = coefs[COEF_A1];
  assign dp_a2      = coefs[COEF_A2];
  assign dp_gain    = coefs[COEF_GAIN];
  sos_coef_bank #(.COEF_SIZE(COEF_SIZE), .NUM_STAGES(NUM_STAGES), .STAGE_W(STAGE_W)) u_bank (
    .clk      (clk),
    .reset    (reset),
    .we       (cfg_we && cfg_ready),
    .wr_stage (cfg_addr[STAGE_W+2:3]),
    .wr_idx   (cfg_addr[2:0]),
    .wr_data  (cfg_data),
    .rd_stage (stage),
    .rd_coefs (coefs)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = sample_trig ? S_START : S_IDLE;
      S_START: state_next = S_WAIT;
      S_WAIT:  state_next = dp_done ? (last ? S_OUT : S_START) : (cnt_hit ? S_IDLE : S_WAIT);
      default: state_next = S_IDLE;
    endcase
  end
  // dp_start is registered, so it rises with the first WAIT cycle and dp_stage/dp_data_in are already stable
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      work        <= '0;
      stage       <= '0;
      cnt         <= '0;
      dp_start    <= 1'b0;
      dp_data_in  <= '0;
      data_out    <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      dp_start <= state == S_START;
      if (state == S_IDLE && sample_trig) begin
        work  <= data_in;
        stage <= '0;
      end
      if (state == S_START) begin
        dp_data_in <= work;
        cnt        <= '0;
      end
      if (state == S_WAIT) begin
        if (dp_done) begin
          work <= dp_data_out;
          if (last) data_out <= dp_data_out;
          else      stage <= stage + STAGE_W'(1);
        end else cnt <= cnt + CNT_W'(1);
      end
      overrun     <= (sample_trig && busy) || (overrun && !err_clr);
      timeout_err <= (state == S_WAIT && !dp_done && cnt_hit) || (timeout_err && !err_clr);
    end
endmodule

// File: tb/tb_sos_cascade_sequencer.sv
// tb_sos_cascade_sequencer: randomized scoreboard bench with a fixed-latency datapath model and a cascade reference model
module tb_sos_cascade_sequencer;
  import sos_cascade_sequencer_pkg::*;
  localparam int CS = 20, DS = 24, NS = 4, TO = 255;
  localparam int SW = stage_w(NS);
  localparam logic [CS-1:0] ONE = 20'd262144;

  logic clk = 0, reset = 1;
  logic [DS-1:0] data_in = '0, data_out, dp_data_in, dp_data_out;
  logic sample_trig = 0, data_valid, busy, overrun, timeout_err, err_clr = 0;
  logic cfg_we = 0, cfg_ready, dp_start, dp_done;
  logic [SW+2:0] cfg_addr = '0;
  logic [CS-1:0] cfg_data = '0, dp_b0, dp_b1, dp_b2, dp_a1, dp_a2, dp_gain;
  logic [SW-1:0] dp_stage;

  sos_cascade_sequencer #(.COEF_SIZE(CS), .DATA_SIZE(DS), .NUM_STAGES(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .sample_trig(sample_trig), .data_out(data_out),
    .data_valid(data_valid), .busy(busy), .overrun(overrun), .timeout_err(timeout_err), .err_clr(err_clr),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .dp_start(dp_start), .dp_stage(dp_stage), .dp_data_in(dp_data_in),
    .dp_b0(dp_b0), .dp_b1(dp_b1), .dp_b2(dp_b2), .dp_a1(dp_a1), .dp_a2(dp_a2), .dp_gain(dp_gain),
    .dp_done(dp_done), .dp_data_out(dp_data_out)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0, errors = 0, nvalid = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference coefficient bank and cascade model
  logic [CS-1:0] rb [NS][6];
  int mode = 0, lat = 3;
  bit dp_en = 1;
  task automatic ref_reset();
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < 6; i++) rb[s][i] = (i == 0 || i == 5) ? ONE : '0;
  endtask
  function automatic logic [DS-1:0] stage_fn(logic [DS-1:0] x, int s, logic [CS-1:0] c0, c1, c2, c3, c4, c5);
    logic [CS-1:0] mix;
    mix = c0 ^ c1 ^ c2 ^ c3 ^ c4 ^ c5;
    if (mode == 0) return x;
    if (mode == 1) return x + 24'd1;
    return x + DS'(s) + 24'd1 + {12'b0, mix[11:0]};
  endfunction
  function automatic logic [DS-1:0] ref_cascade(logic [DS-1:0] x);
    logic [DS-1:0] y = x;
    for (int s = 0; s < NS; s++) y = stage_fn(y, s, rb[s][0], rb[s][1], rb[s][2], rb[s][3], rb[s][4], rb[s][5]);
    return y;
  endfunction

  // datapath model: answers L_dp cycles after the dp_start cycle
  int stages_seen[$];
  logic [CS-1:0] b1_seen[$];
  logic [DS-1:0] dp_v;
  initial begin
    dp_done = 0;
    dp_data_out = '0;
    forever begin
      @(posedge clk); #1;
      if (dp_start && dp_en) begin
        dp_v = stage_fn(dp_data_in, int'(dp_stage), dp_b0, dp_b1, dp_b2, dp_a1, dp_a2, dp_gain);
        stages_seen.push_back(int'(dp_stage));
        b1_seen.push_back(dp_b1);
        repeat (lat) @(posedge clk);
        #1 dp_done = 1; dp_data_out = dp_v;
        @(posedge clk); #1 dp_done = 0;
      end
    end
  end

  // scoreboard
  typedef struct { logic [DS-1:0] val; int at; } exp_t;
  exp_t exp_q[$];
  logic [DS-1:0] last_out = '0;
  always @(negedge clk) if (reset && data_valid) begin
    exp_t e;
    nvalid++;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_valid: got data_out %0h with nothing expected (t=%0t)", data_out, $time);
    end else begin
      e = exp_q.pop_front();
      chk("data_out", data_out, e.val);
      chk("latency_cycle", cyc, e.at);
      last_out = e.val;
    end
  end

  // all driver tasks start and end 1 time unit after a rising edge
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic cfg_write(int s, int idx, logic [CS-1:0] d, bit accept);
    cfg_we = 1; cfg_addr = {SW'(s), 3'(idx)}; cfg_data = d;
    if (accept && idx < 6 && s < NS) rb[s][idx] = d;
    tick();
    cfg_we = 0;
  endtask
  task automatic trig(logic [DS-1:0] x, bit run);
    sample_trig = 1; data_in = x;
    if (run) exp_q.push_back('{ref_cascade(x), cyc + 1 + NS * (2 + lat)});
    tick();
    sample_trig = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d results still outstanding", exp_q.size());
      exp_q.delete();
    end
    tick(2);
  endtask

  initial begin
    int v0, tcyc, ew;
    logic [CS-1:0] d;
    ref_reset();
    #2 reset = 0;
    tick(2);
    chk("rst_data_out", data_out, 0);
    chk("rst_flags", {data_valid, busy, overrun, timeout_err, dp_start, cfg_ready}, 6'b000001);
    chk("rst_dp_in", {dp_data_in, 30'(dp_stage)}, 0);
    chk("rst_coefs", {dp_b0, dp_b1, dp_b2, dp_a1, dp_a2, dp_gain}, {ONE, 80'b0, ONE});
    reset = 1;
    tick(2);

    // pass-through cascade, exact latency and stage order
    mode = 0; lat = 3; stages_seen.delete();
    trig(24'h001000, 1);
    drain();
    chk("pass_valid_count", nvalid, 1);
    chk("stage_count", stages_seen.size(), NS);
    for (int s = 0; s < NS && s < stages_seen.size(); s++) chk("stage_order", stages_seen[s], s);

    // B1 on stage 2 only; out-of-range indices dropped
    mode = 2;
    cfg_write(2, 1, 20'd720683, 1);
    cfg_write(1, 7, 20'hABCDE, 1);
    cfg_write(3, 6, 20'h12345, 1);
    b1_seen.delete();
    trig(24'h00ABCD, 1);
    drain();
    chk("b1_seen_count", b1_seen.size(), NS);
    for (int s = 0; s < NS && s < b1_seen.size(); s++) chk("b1_per_stage", b1_seen[s], s == 2 ? 720683 : 0);

    // +1 per stage
    mode = 1;
    trig(24'd100, 1);
    drain();
    chk("plus_one_out", data_out, 104);

    // overrun, set beating clear, write while busy
    v0 = nvalid;
    trig(24'd500, 1);
    tick(2);
    err_clr = 1;
    trig(24'd999, 0);
    err_clr = 0;
    @(negedge clk);
    chk("overrun_set", overrun, 1);
    chk("busy_cfg_ready", cfg_ready, 0);
    #4;
    cfg_write(0, 0, 20'h12345, 0);
    drain();
    chk("overrun_one_valid", nvalid - v0, 1);
    chk("overrun_sticky", overrun, 1);
    err_clr = 1; tick(); err_clr = 0;
    chk("overrun_clear", overrun, 0);
    mode = 2;
    trig(24'h345678, 1);
    drain();

    // write and trigger in the same idle cycle
    d = 20'($urandom);
    cfg_we = 1; cfg_addr = {SW'(1), 3'(4)}; cfg_data = d; rb[1][4] = d;
    trig(24'h0F0F0F, 1);
    cfg_we = 0;
    drain();

    // randomized coefficients, data and datapath latency
    for (int k = 0; k < 25; k++) begin
      lat = $urandom_range(1, 4);
      repeat ($urandom_range(0, 2)) cfg_write($urandom_range(0, NS - 1), $urandom_range(0, 7), 20'($urandom), 1);
      trig(24'($urandom), 1);
      drain();
    end

    // watchdog timeout
    dp_en = 0; mode = 1; lat = 3;
    v0 = nvalid;
    trig(24'd7, 0);
    ew = -1;
    for (int i = 0; i < 10 && ew < 0; i++) begin
      if (dp_start) ew = cyc;
      else tick();
    end
    chk("timeout_dp_start_seen", ew >= 0, 1);
    tcyc = -1;
    for (int i = 0; i < TO + 20 && tcyc < 0; i++) begin
      @(negedge clk);
      if (timeout_err) tcyc = cyc;
    end
    chk("timeout_cycle", tcyc, ew + TO);
    chk("timeout_not_busy", busy, 0);
    chk("timeout_data_held", data_out, last_out);
    tick(3);
    chk("timeout_no_valid", nvalid - v0, 0);
    dp_en = 1;
    trig(24'd200, 1);
    drain();
    chk("after_timeout_out", data_out, 204);
    chk("timeout_sticky", timeout_err, 1);

    // asynchronous reset in the WAIT of stage 1
    cfg_write(0, 1, 20'd77, 1);
    trig(24'd300, 1);
    tick(2);
    trig(24'd301, 0);
    ew = 0;
    for (int i = 0; i < 40 && ew == 0; i++) begin
      if (dp_start && dp_stage == 1) ew = 1;
      else tick();
    end
    chk("reach_stage1", ew, 1);
    chk("pre_reset_overrun", overrun, 1);
    #2 reset = 0;
    #1;
    chk("async_rst_flags", {data_valid, busy, overrun, timeout_err, dp_start, cfg_ready}, 6'b000001);
    chk("async_rst_data", {data_out, dp_data_in, 8'(dp_stage)}, 0);
    chk("async_rst_coefs", {dp_b0, dp_b1, dp_gain}, {ONE, 20'b0, ONE});
    exp_q.delete();
    ref_reset();
    v0 = nvalid;
    tick(2);
    reset = 1;
    tick(15);
    chk("reset_no_valid", nvalid - v0, 0);
    mode = 2;
    trig(24'($urandom), 1);
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end
endmodule
